// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the core's
//   instruction-fetch port and its load/store data port. Each access is
//   issued with a one-cycle m_en strobe, waits WAIT_STATES cycles, captures
//   m_rdata into the owning port's rdata register and pulses that port's ack.
//   Data requests win collisions unless the fetch port has already been
//   passed over STARVE_MAX times.
//
// Ports
//   clk, rst              clock and asynchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_ack)
//   if_rdata/if_ack       fetched word and one-cycle completion pulse
//   d_req/d_addr/d_we/
//   d_wdata               data request (d_we == 0 means load)
//   d_rdata/d_ack         load word and one-cycle completion pulse
//   m_en/m_addr/m_we/
//   m_wdata/m_rdata       registered memory interface
//   stall                 combinational: a request is pending and not acked
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall
);

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [3:0]          wait_q,     wait_d;
  logic [3:0]          starve_q,   starve_d;
  logic                m_en_q,     m_en_d;
  logic [3:0]          m_we_q,     m_we_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                if_ack_q,   if_ack_d;
  logic                d_ack_q,    d_ack_d;

  // A port acked this cycle is about to drop its request, so it must not be
  // granted again on the strength of the stale level.
  logic i_elig, d_elig;
  assign i_elig = if_req & ~if_ack_q;
  assign d_elig = d_req  & ~d_ack_q;

  // Arbitration, access sequencing and next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    m_en_d     = 1'b0;
    m_we_d     = 4'b0000;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins a collision unless fetch has been passed over STARVE_MAX times.
        if (d_elig && (!i_elig || (starve_q != STARVE_LIM))) begin
          state_d   = BUSY_D;
          wait_d    = WAIT_INIT;
          m_en_d    = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          // if_req may be high only because its ack is in this cycle; that
          // still counts towards the starvation count.
          if (if_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else if (i_elig) begin
          state_d   = BUSY_I;
          wait_d    = WAIT_INIT;
          m_en_d    = 1'b1;
          m_we_d    = 4'b0000;
          m_addr_d  = if_addr;
          m_wdata_d = {DATA_W{1'b0}};
          starve_d  = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I, BUSY_D: begin
        // wait_q reaches zero in the cycle m_rdata is valid.
        if (wait_q == 4'd0) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            if_rdata_d = m_rdata;
            if_ack_d   = 1'b1;
          end else begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 4'd0;
      starve_q   <= 4'd0;
      m_en_q     <= 1'b0;
      m_we_q     <= 4'b0000;
      m_addr_q   <= {ADDR_W{1'b0}};
      m_wdata_q  <= {DATA_W{1'b0}};
      if_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q  <= {DATA_W{1'b0}};
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_ack    = d_ack_q;
  assign stall    = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance dut uses the default
// parameters with a memory whose data is m_addr ^ 32'hDEADBFEF; instance
// dut_b uses WAIT_STATES=3, STARVE_MAX=1 with m_rdata driven per cycle.
// Cycle c of a test is the interval after its c-th rising edge; inputs are
// driven 1ns after the rising edge, outputs checked on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req = 1'b0, d_req = 1'b0;
  logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [3:0]  d_we = 4'h0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        if_ack, d_ack, m_en, stall;
  logic [3:0]  m_we;

  logic        b_if_req = 1'b0, b_d_req = 1'b0;
  logic [31:0] b_if_addr = 32'h0, b_d_addr = 32'h0, b_m_rdata = 32'h0;
  logic [31:0] b_if_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic        b_if_ack, b_d_ack, b_m_en, b_stall;
  logic [3:0]  b_m_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_rdata = m_addr ^ 32'hDEADBFEF;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall(stall)
  );

  mem_port_arbiter #(.WAIT_STATES(3), .STARVE_MAX(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_addr(b_d_addr), .d_we(4'h0), .d_wdata(32'h0),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .m_en(b_m_en), .m_addr(b_m_addr), .m_we(b_m_we), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata), .stall(b_stall)
  );

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({m_en, m_we, if_ack, d_ack, stall} !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", {m_en, m_we, if_ack, d_ack, stall}); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m got %h/%h exp 0/0", m_addr, m_wdata); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", if_rdata, d_rdata); end
    checks++; if ({b_m_en, b_if_ack, b_d_ack, b_stall} !== 4'h0) begin errors++; $display("FAIL reset_b got %h exp 0", {b_m_en, b_if_ack, b_d_ack, b_stall}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_load();
    d_req = 1'b1; d_addr = 32'h0000_0100; d_we = 4'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (m_en !== (c == 1)) begin errors++; $display("FAIL load_m_en c%0d got %b exp %b", c, m_en, (c == 1)); end
      checks++; if (d_ack !== (c == 3)) begin errors++; $display("FAIL load_d_ack c%0d got %b exp %b", c, d_ack, (c == 3)); end
      checks++; if (stall !== (c < 3)) begin errors++; $display("FAIL load_stall c%0d got %b exp %b", c, stall, (c < 3)); end
      if (c == 1) begin
        checks++; if (m_addr !== 32'h0000_0100) begin errors++; $display("FAIL load_m_addr got %h exp 00000100", m_addr); end
      end
      if (c == 3) begin
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_d_rdata got %h exp deadbeef", d_rdata); end
      end
      @(posedge clk); #1;
      if (c == 3) d_req = 1'b0;
    end
  endtask

  task automatic test_store();
    logic [3:0] exp_we;
    d_req = 1'b1; d_addr = 32'h0000_0200; d_we = 4'b0011; d_wdata = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp_we = (c == 1) ? 4'b0011 : 4'b0000;
      checks++; if (m_we !== exp_we) begin errors++; $display("FAIL store_m_we c%0d got %b exp %b", c, m_we, exp_we); end
      checks++; if (d_ack !== (c == 3)) begin errors++; $display("FAIL store_d_ack c%0d got %b exp %b", c, d_ack, (c == 3)); end
      if (c >= 1 && c <= 3) begin
        checks++; if (m_wdata !== 32'h1234_5678) begin errors++; $display("FAIL store_m_wdata c%0d got %h exp 12345678", c, m_wdata); end
        checks++; if (m_addr !== 32'h0000_0200) begin errors++; $display("FAIL store_m_addr c%0d got %h exp 00000200", c, m_addr); end
      end
      @(posedge clk); #1;
      if (c == 3) begin d_req = 1'b0; d_we = 4'h0; d_wdata = 32'h0; end
    end
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    d_req  = 1'b1; d_addr  = 32'h0000_0104;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (m_en !== (c == 1 || c == 4)) begin errors++; $display("FAIL coll_m_en c%0d got %b exp %b", c, m_en, (c == 1 || c == 4)); end
      checks++; if (d_ack !== (c == 3)) begin errors++; $display("FAIL coll_d_ack c%0d got %b exp %b", c, d_ack, (c == 3)); end
      checks++; if (if_ack !== (c == 6)) begin errors++; $display("FAIL coll_if_ack c%0d got %b exp %b", c, if_ack, (c == 6)); end
      checks++; if (stall !== (c < 6)) begin errors++; $display("FAIL coll_stall c%0d got %b exp %b", c, stall, (c < 6)); end
      if (c == 1) begin
        checks++; if (m_addr !== 32'h0000_0104) begin errors++; $display("FAIL coll_m_addr_d got %h exp 00000104", m_addr); end
      end
      if (c == 2) begin
        checks++; if (dut.starve_q !== 4'd1) begin errors++; $display("FAIL coll_starve_inc got %0d exp 1", dut.starve_q); end
      end
      if (c == 3) begin
        checks++; if (d_rdata !== 32'hDEADBEEB) begin errors++; $display("FAIL coll_d_rdata got %h exp deadbeeb", d_rdata); end
      end
      if (c == 4) begin
        checks++; if (m_addr !== 32'h0000_0040) begin errors++; $display("FAIL coll_m_addr_i got %h exp 00000040", m_addr); end
      end
      if (c == 5) begin
        checks++; if (dut.starve_q !== 4'd0) begin errors++; $display("FAIL coll_starve_clr got %0d exp 0", dut.starve_q); end
      end
      if (c == 6) begin
        checks++; if (if_rdata !== 32'hDEADBFAF) begin errors++; $display("FAIL coll_if_rdata got %h exp deadbfaf", if_rdata); end
      end
      @(posedge clk); #1;
      if (c == 3) d_req = 1'b0;
      if (c == 6) if_req = 1'b0;
    end
  endtask

  task automatic test_wait_states();
    b_if_req = 1'b1; b_if_addr = 32'h0000_0300;
    for (int c = 0; c < 7; c++) begin
      case (c)
        1: b_m_rdata = 32'h1111_1111;
        2: b_m_rdata = 32'h2222_2222;
        3: b_m_rdata = 32'h3333_3333;
        4: b_m_rdata = 32'hCAFE_F00D;
        5: b_m_rdata = 32'h5555_5555;
        default: b_m_rdata = 32'h0;
      endcase
      @(negedge clk);
      checks++; if (b_m_en !== (c == 1)) begin errors++; $display("FAIL ws3_m_en c%0d got %b exp %b", c, b_m_en, (c == 1)); end
      checks++; if (b_if_ack !== (c == 5)) begin errors++; $display("FAIL ws3_if_ack c%0d got %b exp %b", c, b_if_ack, (c == 5)); end
      checks++; if (b_stall !== (c < 5)) begin errors++; $display("FAIL ws3_stall c%0d got %b exp %b", c, b_stall, (c < 5)); end
      if (c >= 5) begin
        checks++; if (b_if_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws3_if_rdata c%0d got %h exp cafef00d", c, b_if_rdata); end
      end
      @(posedge clk); #1;
      if (c == 5) b_if_req = 1'b0;
    end
  endtask

  task automatic test_starvation();
    logic exp_en;
    b_if_req = 1'b1; b_if_addr = 32'h0000_0010;
    for (int c = 0; c < 24; c++) begin
      if (c == 1)  begin b_d_req = 1'b1; b_d_addr = 32'h0000_0020; end
      if (c == 12) begin b_if_req = 1'b1; b_if_addr = 32'h0000_0030; b_d_req = 1'b1; b_d_addr = 32'h0000_0040; end
      @(negedge clk);
      exp_en = (c == 1 || c == 6 || c == 13 || c == 18);
      checks++; if (b_m_en !== exp_en) begin errors++; $display("FAIL starve_m_en c%0d got %b exp %b", c, b_m_en, exp_en); end
      checks++; if (b_if_ack !== (c == 5 || c == 17)) begin errors++; $display("FAIL starve_if_ack c%0d got %b exp %b", c, b_if_ack, (c == 5 || c == 17)); end
      checks++; if (b_d_ack !== (c == 10 || c == 22)) begin errors++; $display("FAIL starve_d_ack c%0d got %b exp %b", c, b_d_ack, (c == 10 || c == 22)); end
      if (c == 6) begin
        checks++; if (b_m_addr !== 32'h0000_0020) begin errors++; $display("FAIL starve_addr6 got %h exp 00000020", b_m_addr); end
        checks++; if (dut_b.starve_q !== 4'd1) begin errors++; $display("FAIL starve_cnt6 got %0d exp 1", dut_b.starve_q); end
      end
      if (c == 13) begin
        checks++; if (b_m_addr !== 32'h0000_0030) begin errors++; $display("FAIL starve_guard_addr got %h exp 00000030", b_m_addr); end
        checks++; if (dut_b.starve_q !== 4'd0) begin errors++; $display("FAIL starve_cnt13 got %0d exp 0", dut_b.starve_q); end
      end
      if (c == 18) begin
        checks++; if (b_m_addr !== 32'h0000_0040) begin errors++; $display("FAIL starve_addr18 got %h exp 00000040", b_m_addr); end
        checks++; if (dut_b.starve_q !== 4'd1) begin errors++; $display("FAIL starve_sat got %0d exp 1", dut_b.starve_q); end
      end
      @(posedge clk); #1;
      if (c == 5 || c == 17) b_if_req = 1'b0;
      if (c == 10 || c == 22) b_d_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_addr = 32'h0000_0104; d_we = 4'h0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (m_en !== 1'b1) begin errors++; $display("FAIL rstmid_issue got %b exp 1", m_en); end
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    #1;
    checks++; if ({m_en, m_we, d_ack, if_ack} !== 7'h00) begin errors++; $display("FAIL rstmid_ctrl got %h exp 00", {m_en, m_we, d_ack, if_ack}); end
    checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_m got %h/%h exp 0/0", m_addr, m_wdata); end
    checks++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h/%h exp 0/0", d_rdata, if_rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (d_ack !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL rstmid_quiet c%0d got ack %b en %b exp 0 0", c, d_ack, m_en); end
      @(posedge clk); #1;
    end
    d_req = 1'b1; d_addr = 32'h0000_0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (m_en !== (c == 1)) begin errors++; $display("FAIL rstmid_m_en c%0d got %b exp %b", c, m_en, (c == 1)); end
      checks++; if (d_ack !== (c == 3)) begin errors++; $display("FAIL rstmid_d_ack c%0d got %b exp %b", c, d_ack, (c == 3)); end
      if (c == 3) begin
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_d_rdata got %h exp deadbeef", d_rdata); end
      end
      @(posedge clk); #1;
      if (c == 3) d_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_collision();
    test_wait_states();
    test_starvation();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
